// File: rtl/pc_fetch.sv
// Fetch stage: one outstanding imem read at a time, result held for decode until accepted or flushed.
// One instruction per two cycles with zero-wait memory; decode stalls hold the stage in HOLD.
module pc_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  output logic [31:0] nowpc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        align_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_nowpc;
  logic [31:0] r_instr_out;
  logic        r_instr_valid;
  logic        r_align_err;
  logic [15:0] r_fetch_count;

  logic [31:0] w_flush_tgt;
  logic        w_flush_mis;
  logic [31:0] w_npc_tgt;
  logic        w_npc_mis;

  assign w_flush_tgt = {flush_pc[31:2], 2'b00};
  assign w_flush_mis = |flush_pc[1:0];
  assign w_npc_tgt   = {npc_in[31:2], 2'b00};
  assign w_npc_mis   = |npc_in[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_REQ;
      r_pc          <= PC_RESET;
      r_drop_addr   <= 32'h0;
      r_nowpc       <= 32'h0;
      r_instr_out   <= 32'h0;
      r_instr_valid <= 1'b0;
      r_align_err   <= 1'b0;
      r_fetch_count <= 16'h0;
    end else begin
      r_align_err <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (flush) begin
            r_pc        <= w_flush_tgt;
            r_align_err <= w_flush_mis;
            // Without an ack the read is still in flight: keep its address until it completes.
            if (!imem_ack) begin
              r_drop_addr <= r_pc;
              r_state     <= S_DROP;
            end
          end else if (imem_ack) begin
            r_instr_out   <= imem_rdata;
            r_nowpc       <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (flush) begin
            r_pc          <= w_flush_tgt;
            r_align_err   <= w_flush_mis;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end else if (r_instr_valid && instr_ready) begin
            r_pc          <= w_npc_tgt;
            r_align_err   <= w_npc_mis;
            r_instr_valid <= 1'b0;
            r_fetch_count <= r_fetch_count + 16'd1;
            r_state       <= S_REQ;
          end
        end
        S_DROP: begin
          if (flush) begin
            r_pc        <= w_flush_tgt;
            r_align_err <= w_flush_mis;
          end
          if (imem_ack) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign imem_req    = !reset && (r_state != S_HOLD);
  assign imem_addr   = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign nowpc       = r_nowpc;
  assign instr_out   = r_instr_out;
  assign instr_valid = r_instr_valid;
  assign align_err   = r_align_err;
  assign fetch_count = r_fetch_count;

endmodule
